serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial, LSB-first subtractor that computes A - B over WIDTH cycles.
//  It uses one full-subtractor cell and a registered borrow.
//  It is the inverse-operation companion to our combinational full adder (FA).
//  Sits beside FA-based datapaths where area matters more than latency.
//  Also serves as a self-checking reference for adder benches: (a+b)-b == a.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  start_in       in   1      request; operands sampled when accepted
//  a_in           in   WIDTH  minuend, unsigned
//  b_in           in   WIDTH  subtrahend, unsigned
//  busy_out       out  1      high while state != IDLE
//  diff_bit_out   out  1      serial difference bit, LSB first
//  diff_bit_valid_out out 1   high while diff_bit_out is valid (SHIFT state)
//  diff_out       out  WIDTH  parallel result; held until next accepted start
//  borrow_out     out  1      final borrow; 1 => a_in < b_in (unsigned)
//  done_out       out  1      one-cycle pulse when diff_out and borrow_out update
// BEHAVIOUR
//  Reset: one clock, asynchronous, active-low (rst_n).
//  - Asserting rst_n low forces state=IDLE and clears every register.
//  - All outputs read 0 while in reset, including mid-operation.
//  - There is no partial result after reset.
//  FSM states: IDLE, SHIFT, DONE.
//  - IDLE -> SHIFT when start_in=1. On that edge:
//    capture a_in/b_in into shift regs, clear borrow flop, set bit counter cnt=0.
//  - SHIFT: each cycle, cell inputs are a_sr[0], b_sr[0] and the borrow flop.
//    diff_bit_out = a^b^bin (combinational from regs).
//    diff_bit_valid_out=1 throughout SHIFT.
//  - SHIFT, each edge: borrow <= (~a&b)|(~(a^b)&bin).
//    Shift a_sr and b_sr right by one.
//    Shift diff bit into res_sr MSB. cnt++.
//  - SHIFT -> DONE on the edge where cnt==WIDTH-1.
//    diff_out <= final res_sr; borrow_out <= final borrow.
//  - DONE: done_out=1 for exactly one cycle.
//    Next state is SHIFT if start_in=1 (back-to-back, same capture as IDLE), else IDLE.
//  - start_in during SHIFT is ignored. It is not queued.
//  Timing: start sampled at edge t.
//  - Bit i is valid in cycle t+1+i.
//  - done_out is high in cycle t+WIDTH+1. Latency is WIDTH+1 cycles.
//  - Throughput is one op per WIDTH+1 cycles.
//  Arithmetic: diff_out = (a_in - b_in) mod 2^WIDTH; borrow_out = (a_in < b_in).
//  Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1.
//  diff_out and borrow_out change only on the DONE-entry edge or on reset.
// STRUCTURE
//  Package serial_sub_pkg holds:
//  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
//  - localparam DEFAULT_WIDTH = 8
//  Sub-module full_subtractor (combinational):
//  - inputs: a_in, b_in, borrow_in
//  - outputs: diff_out, borrow_out
//  - instantiated once.
//  Top holds the FSM, counter, operand/result shift registers and the borrow flop.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles, then release.
//     -> all outputs 0, busy_out=0.
//  2. a=8'd5, b=8'd3, start.
//     -> serial bits 0,1,0,0,0,0,0,0.
//     -> done in cycle t+9, diff_out=8'h02, borrow_out=0.
//  3. a=8'h00, b=8'h01.
//     -> diff_out=8'hFF, borrow_out=1.
//  3b. a=8'd3, b=8'd5.
//     -> diff_out=8'hFE, borrow_out=1.
//  4. Hold start_in=1 continuously with a=8'hA5, b=8'h5A.
//     -> start during SHIFT is ignored.
//     -> DONE at t+9 with 8'h4B, borrow 0.
//     -> next op begins t+10 (restart from DONE); done pulses every 9 cycles.
//  5. rst_n low at bit 4 of 8'hFF-8'h01.
//     -> outputs clear immediately.
//     -> no done_out after release; next op 8'h10-8'h01 gives 8'h0F.
//  6. 1000 random a/b via $urandom.
//     -> diff_out==(a-b)&8'hFF, borrow_out==(a<b).
//     -> exactly one done_out per accepted start.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - borrow_in.
module full_subtractor (
  input  logic a_in,
  input  logic b_in,
  input  logic borrow_in,
  output logic diff_out,
  output logic borrow_out
);

  assign diff_out   = a_in ^ b_in ^ borrow_in;
  assign borrow_out = (~a_in & b_in) | (~(a_in ^ b_in) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first A - B using one full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             diff_bit_out,
  output logic             diff_bit_valid_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             done_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_diff;
  logic             cell_borrow;

  full_subtractor u_cell (
    .a_in       (a_sr[0]),
    .b_in       (b_sr[0]),
    .borrow_in  (borrow),
    .diff_out   (cell_diff),
    .borrow_out (cell_borrow)
  );

  assign busy_out           = (state != IDLE);
  assign diff_bit_valid_out = (state == SHIFT);
  // Gate so that leftover register contents never show outside SHIFT.
  assign diff_bit_out       = (state == SHIFT) & cell_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= cell_borrow;
          res_sr <= {cell_diff, res_sr[WIDTH-1:1]};
          // Counter saturates at the last bit; the final bit goes straight to diff_out.
          if (cnt == LAST_BIT) begin
            diff_out   <= {cell_diff, res_sr[WIDTH-1:1]};
            borrow_out <= cell_borrow;
            done_out   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         diff_bit_out;
  logic         diff_bit_valid_out;
  logic [W-1:0] diff_out;
  logic         borrow_out;
  logic         done_out;

  int assert_count;
  int fail_count;
  int done_seen;
  int done_expected;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_in           (start_in),
    .a_in               (a_in),
    .b_in               (b_in),
    .busy_out           (busy_out),
    .diff_bit_out       (diff_bit_out),
    .diff_bit_valid_out (diff_bit_valid_out),
    .diff_out           (diff_out),
    .borrow_out         (borrow_out),
    .done_out           (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses independently of the directed checks.
  always @(negedge clk) if (done_out === 1'b1) done_seen++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, {31'd0, busy_out}, 32'd0);
    checkOutput({tag, " bit"}, {31'd0, diff_bit_out}, 32'd0);
    checkOutput({tag, " valid"}, {31'd0, diff_bit_valid_out}, 32'd0);
    checkOutput({tag, " diff"}, {24'd0, diff_out}, 32'd0);
    checkOutput({tag, " borrow"}, {31'd0, borrow_out}, 32'd0);
    checkOutput({tag, " done"}, {31'd0, done_out}, 32'd0);
  endtask

  // Runs one op from idle; called and returns on a negedge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_diff, input logic exp_borrow,
                               input bool_full);
    a_in = a;
    b_in = b;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bool_full) begin
        checkOutput("shift valid", {31'd0, diff_bit_valid_out}, 32'd1);
        checkOutput("shift done", {31'd0, done_out}, 32'd0);
      end
      checkOutput($sformatf("serial bit %0d", i), {31'd0, diff_bit_out}, {31'd0, exp_diff[i]});
      @(negedge clk);
    end
    checkOutput("done pulse", {31'd0, done_out}, 32'd1);
    checkOutput("diff_out", {24'd0, diff_out}, {24'd0, exp_diff});
    checkOutput("borrow_out", {31'd0, borrow_out}, {31'd0, exp_borrow});
    done_expected++;
    @(negedge clk);
    checkOutput("done one cycle", {31'd0, done_out}, 32'd0);
    checkOutput("idle busy", {31'd0, busy_out}, 32'd0);
    checkOutput("diff held", {24'd0, diff_out}, {24'd0, exp_diff});
  endtask

  vec_t vecs[4];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    assert_count  = 0;
    fail_count    = 0;
    done_seen     = 0;
    done_expected = 0;
    rst_n    = 1'b0;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;

    vecs[0] = '{a: 8'd5,   b: 8'd3,   diff: 8'h02, borrow: 1'b0};
    vecs[1] = '{a: 8'h00,  b: 8'h01,  diff: 8'hFF, borrow: 1'b1};
    vecs[2] = '{a: 8'd3,   b: 8'd5,   diff: 8'hFE, borrow: 1'b1};
    vecs[3] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00, borrow: 1'b0};

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post reset");

    for (int v = 0; v < 4; v++)
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].diff, vecs[v].borrow, 1'b1);

    // start held high: restart from DONE every W+1 cycles, starts during SHIFT ignored.
    a_in = 8'hA5;
    b_in = 8'h5A;
    start_in = 1'b1;
    for (int k = 1; k <= 3 * (W + 1); k++) begin
      @(negedge clk);
      if (k == 3 * (W + 1)) start_in = 1'b0;
      checkOutput($sformatf("held start done k=%0d", k), {31'd0, done_out},
                  {31'd0, (k % (W + 1)) == 0});
      checkOutput($sformatf("held start valid k=%0d", k), {31'd0, diff_bit_valid_out},
                  {31'd0, (k % (W + 1)) != 0});
      if (k % (W + 1) == 0) begin
        checkOutput("held diff", {24'd0, diff_out}, 32'h4B);
        checkOutput("held borrow", {31'd0, borrow_out}, 32'd0);
        done_expected++;
      end
    end
    @(negedge clk);
    checkOutput("held released idle", {31'd0, busy_out}, 32'd0);

    // Abort with reset during bit 4 of FF-01.
    a_in = 8'hFF;
    b_in = 8'h01;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort bit4 valid", {31'd0, diff_bit_valid_out}, 32'd1);
    checkOutput("abort bit4 value", {31'd0, diff_bit_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("mid-op reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("no done after abort", {31'd0, done_out}, 32'd0);
      checkOutput("idle after abort", {31'd0, busy_out}, 32'd0);
    end
    applyStimulus(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);

    // Random operands against a reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      applyStimulus(ra, rb, ra - rb, ra < rb, 1'b0);
    end

    checkOutput("done count", done_seen, done_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
